// File: rtl/sip_pkg.sv
// Shared SipHash constants, rotate helper and engine FSM states.
// Imported by the inverse-round engine, its half-round and its bus interface.
package sip_pkg;

  localparam int SIP_W    = 64;
  localparam int ROT_V1_A = 13;
  localparam int ROT_V3_A = 16;
  localparam int ROT_V1_B = 17;
  localparam int ROT_V3_B = 21;
  localparam int ROT_HALF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [SIP_W-1:0] rotr(
    input logic [SIP_W-1:0] x,
    input int               k
  );
    return (x >> k) | (x << (SIP_W - k));
  endfunction

endpackage

// File: rtl/sip_inv_round_engine_if.sv
// Job/result handshake bundle of the inverse-SipRound engine.
// master: job source + result sink; slave: engine.
interface sip_inv_round_engine_if #(
  parameter int CNT_W = 4
);
  import sip_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] in_rounds;
  logic [SIP_W-1:0] v0_in;
  logic [SIP_W-1:0] v1_in;
  logic [SIP_W-1:0] v2_in;
  logic [SIP_W-1:0] v3_in;
  logic             out_valid;
  logic             out_ready;
  logic [SIP_W-1:0] v0_out;
  logic [SIP_W-1:0] v1_out;
  logic [SIP_W-1:0] v2_out;
  logic [SIP_W-1:0] v3_out;

  modport master (
    output in_valid, in_rounds,
    output v0_in, v1_in, v2_in, v3_in,
    output out_ready,
    input  in_ready, out_valid,
    input  v0_out, v1_out, v2_out, v3_out
  );

  modport slave (
    input  in_valid, in_rounds,
    input  v0_in, v1_in, v2_in, v3_in,
    input  out_ready,
    output in_ready, out_valid,
    output v0_out, v1_out, v2_out, v3_out
  );

endinterface

// File: rtl/sip_inv_half_round.sv
// Combinational inverse of one SipHash half-round on lanes (a,b,c,d).
// Ports: a/b/c/d_in state before, a/b/c/d_out state after the inverse.
// Forward half: a+=b; b=rotl(b,V1); b^=a; a=rotl(a,32);
//               c+=d; d=rotl(d,V3); d^=c.
// Half A maps (a,b,c,d)=(v0,v1,v2,v3); half B maps (v2,v1,v0,v3).
module sip_inv_half_round
  import sip_pkg::*;
#(
  parameter int V1_SHIFT = ROT_V1_A,
  parameter int V3_SHIFT = ROT_V3_A
) (
  input  logic [SIP_W-1:0] a_in,
  input  logic [SIP_W-1:0] b_in,
  input  logic [SIP_W-1:0] c_in,
  input  logic [SIP_W-1:0] d_in,
  output logic [SIP_W-1:0] a_out,
  output logic [SIP_W-1:0] b_out,
  output logic [SIP_W-1:0] c_out,
  output logic [SIP_W-1:0] d_out
);

  logic [SIP_W-1:0] d_x;
  logic [SIP_W-1:0] a_r;
  logic [SIP_W-1:0] b_x;

  // c/d pair
  assign d_x   = d_in ^ c_in;
  assign d_out = rotr(d_x, V3_SHIFT);
  assign c_out = c_in - d_out;

  // a/b pair
  assign a_r   = rotr(a_in, ROT_HALF);
  assign b_x   = b_in ^ a_r;
  assign b_out = rotr(b_x, V1_SHIFT);
  assign a_out = a_r - b_out;

endmodule

// File: rtl/sip_inv_round_engine.sv
// Iterative inverse-SipRound engine: undoes in_rounds SipRounds,
// one inverse half-round (B then A) per clock.
// Ports: clk, rst (sync, active-high), bus (slave): job in / result out.
module sip_inv_round_engine
  import sip_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int V1_SHIFT_A = ROT_V1_A,
  parameter int V3_SHIFT_A = ROT_V3_A,
  parameter int V1_SHIFT_B = ROT_V1_B,
  parameter int V3_SHIFT_B = ROT_V3_B
) (
  input  logic                  clk,
  input  logic                  rst,
  sip_inv_round_engine_if.slave bus
);

  localparam logic [CNT_W:0] CNT_ONE = 1;

  state_e           state;
  logic [SIP_W-1:0] v0, v1, v2, v3;
  logic [CNT_W:0]   cnt;
  logic             phase_a;

  logic [SIP_W-1:0] b0, b1, b2, b3;
  logic [SIP_W-1:0] a0, a1, a2, a3;
  logic [SIP_W-1:0] n0, n1, n2, n3;

  sip_inv_half_round #(
    .V1_SHIFT (V1_SHIFT_B),
    .V3_SHIFT (V3_SHIFT_B)
  ) u_half_b (
    .a_in  (v2), .b_in  (v1), .c_in  (v0), .d_in  (v3),
    .a_out (b2), .b_out (b1), .c_out (b0), .d_out (b3)
  );

  sip_inv_half_round #(
    .V1_SHIFT (V1_SHIFT_A),
    .V3_SHIFT (V3_SHIFT_A)
  ) u_half_a (
    .a_in  (v0), .b_in  (v1), .c_in  (v2), .d_in  (v3),
    .a_out (a0), .b_out (a1), .c_out (a2), .d_out (a3)
  );

  // Inverse round = inverse B first, then inverse A.
  assign n0 = phase_a ? a0 : b0;
  assign n1 = phase_a ? a1 : b1;
  assign n2 = phase_a ? a2 : b2;
  assign n3 = phase_a ? a3 : b3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      v0      <= '0;
      v1      <= '0;
      v2      <= '0;
      v3      <= '0;
      cnt     <= '0;
      phase_a <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (bus.in_valid) begin
            v0      <= bus.v0_in;
            v1      <= bus.v1_in;
            v2      <= bus.v2_in;
            v3      <= bus.v3_in;
            cnt     <= {bus.in_rounds, 1'b0};
            phase_a <= 1'b0;
            state   <= (~|bus.in_rounds) ? DONE : RUN;
          end
        end
        (state == RUN): begin
          v0      <= n0;
          v1      <= n1;
          v2      <= n2;
          v3      <= n3;
          phase_a <= ~phase_a;
          cnt     <= cnt - 1'b1;
          if (cnt == CNT_ONE) state <= DONE;
        end
        (state == DONE): begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.v0_out    = v0;
  assign bus.v1_out    = v1;
  assign bus.v2_out    = v2;
  assign bus.v3_out    = v3;

endmodule
